muldiv_sequencer: RTL and testbench
===================================

Name: muldiv_sequencer

Overview:
Multi-cycle sequencer for the MIPS MULT/MULTU/DIV/DIVU instructions and the HI/LO register pair they write. It sits beside the single-cycle ALU in the execute stage and runs an iterative radix-2 shift-add / restoring-divide loop. It raises Busy so the pipeline stalls MFHI/MFLO and new mult/div issue, and owns MTHI/MTLO writes.

Parameters:
WIDTH, 32, operand width; HI and LO are each WIDTH bits
CNT_W, 5, iteration counter width; must equal clog2(WIDTH)

Ports:
Clk  input  1  clock, rising edge
Reset_n  input  1  synchronous, active-low reset
Start  input  1  request a new operation; sampled only when state is IDLE or DONE
Op  input  2  00 MULT, 01 MULTU, 10 DIV, 11 DIVU
A  input  WIDTH  rs operand (multiplicand / dividend)
B  input  WIDTH  rt operand (multiplier / divisor)
WrHi  input  1  MTHI strobe
WrLo  input  1  MTLO strobe
WrData  input  WIDTH  MTHI/MTLO data
Flush  input  1  abort any in-flight operation
Busy  output  1  high while in CALC or FIX
Done  output  1  one-cycle pulse; HI/LO hold the new result in that cycle
DivZero  output  1  sticky per operation; set when a DIV/DIVU is accepted with B==0
Hi  output  WIDTH  HI register
Lo  output  WIDTH  LO register

Behaviour:
- Reset (Reset_n=0 at a rising edge): state IDLE, Hi=0, Lo=0, Busy=0, Done=0, DivZero=0, counter=0. Reset overrides every other input, including mid-operation.
- States and transitions:
  - IDLE: Start -> CALC. Latch |A| and |B| (absolute values for signed ops; raw values for unsigned), the result sign flags, and Op. Clear the counter and DivZero.
  - Divide with B==0: set DivZero and go straight to FIX; no CALC cycles.
  - CALC: one iteration per cycle for WIDTH cycles. At counter==WIDTH-1 -> FIX.
  - FIX: apply sign correction and register Hi/Lo -> DONE.
  - DONE: Done=1 for this one cycle. Start -> CALC (back-to-back issue, same rules as IDLE); otherwise -> IDLE.
- Latency: Start sampled at edge t0, CALC in cycles t1..t32, FIX in t33, Done=1 in t34. Divide-by-zero: FIX in t1, Done in t2.
- Start while Busy=1 is ignored. No queueing.
- Multiply: 2*WIDTH-bit product of the magnitudes. Negate it if the op is MULT and the operand signs differ. Hi=product[63:32], Lo=product[31:0].
- Divide: restoring division on the magnitudes. Negate the quotient if the op is DIV and the signs differ. Negate the remainder if the op is DIV and A is negative. Lo=quotient, Hi=remainder.
- DIV 0x80000000 / 0xFFFFFFFF gives Lo=0x80000000, Hi=0. No trap.
- Divide by zero: Lo=0xFFFFFFFF, Hi=A (the raw operand), DivZero=1 until the next accepted Start.
- WrHi/WrLo: written at the edge only when the state is IDLE or DONE. They are ignored while Busy. If Start is accepted in the same cycle, Start has priority and the write is dropped.
- WrHi and WrLo in the same cycle both write WrData.
- Flush: at the next edge go to IDLE, clear the counter, leave Hi/Lo unchanged, no Done pulse. Flush in the same cycle as Start: Flush wins and nothing is accepted. Flush in DONE: the Done pulse already seen stands, and the state goes to IDLE.
- Hi and Lo change only in FIX, on an MT write, or at reset.

Decomposition:
- Shared package muldiv_pkg: Op encodings (OP_MULT, OP_MULTU, OP_DIV, OP_DIVU), state encoding (S_IDLE, S_CALC, S_FIX, S_DONE), WIDTH default.
- One combinational sub-module, muldiv_step. It takes the partial accumulator/remainder, the shift register and the op class, and returns the next iteration values.
- The sequencer keeps the FSM, the counter, sign handling and the HI/LO registers.

Test Plan:
- Reset held 3 cycles, then released -> Hi=Lo=0, Busy=0, Done=0, DivZero=0.
- MULT A=0xFFFFFFFD (-3), B=7 -> Busy high t1..t33, Done at t34, Hi=0xFFFFFFFF, Lo=0xFFFFFFEB. MULTU with the same operands -> Hi=0x00000006, Lo=0xFFFFFFEB.
- DIV A=-7, B=2 -> Lo=0xFFFFFFFD, Hi=0xFFFFFFFF. DIVU A=0x80000000, B=0xFFFFFFFF -> Lo=0, Hi=0x80000000. DIV 0x80000000 / -1 -> Lo=0x80000000, Hi=0.
- DIVU A=0x1234, B=0 -> Done at t2, DivZero=1, Lo=0xFFFFFFFF, Hi=0x1234. The next accepted Start clears DivZero.
- Start again while Busy, WrHi=1 while Busy, then Flush at t10 -> second Start ignored, Hi unchanged, no Done, IDLE at t11. Start in the Done cycle -> new run begins, second Done 34 cycles later.
- In IDLE, WrHi+WrLo with 0xA5A5A5A5 -> both registers equal 0xA5A5A5A5. Start+WrLo in the same cycle -> WrLo dropped.

Source files
------------

// File: rtl/muldiv_pkg.sv
// Shared definitions for the MULT/MULTU/DIV/DIVU sequencer.
//   - op_e    : operation encodings as presented on the Op port
//   - state_e : sequencer FSM states
//   - MD_WIDTH: default operand width
package muldiv_pkg;

  localparam int MD_WIDTH = 32;

  typedef enum logic [1:0] {
    OP_MULT  = 2'b00,
    OP_MULTU = 2'b01,
    OP_DIV   = 2'b10,
    OP_DIVU  = 2'b11
  } op_e;

  typedef enum logic [1:0] {
    S_IDLE = 2'b00,
    S_CALC = 2'b01,
    S_FIX  = 2'b10,
    S_DONE = 2'b11
  } state_e;

endpackage

// File: rtl/muldiv_step.sv
// One radix-2 iteration of the multiply / divide loop (purely combinational).
//   is_div  : 1 = restoring divide step, 0 = shift-add multiply step
//   acc_i   : partial product high half (multiply) or partial remainder (divide)
//   shreg_i : multiplier being consumed (multiply) or dividend/quotient (divide)
//   opnd_i  : multiplicand (multiply) or divisor (divide)
//   acc_o   : next accumulator / remainder
//   shreg_o : next shift register
module muldiv_step
  import muldiv_pkg::*;
#(
  parameter int WIDTH = MD_WIDTH
) (
  input  logic             is_div,
  input  logic [WIDTH-1:0] acc_i,
  input  logic [WIDTH-1:0] shreg_i,
  input  logic [WIDTH-1:0] opnd_i,
  output logic [WIDTH-1:0] acc_o,
  output logic [WIDTH-1:0] shreg_o
);

  logic [WIDTH-1:0] addend;
  logic [WIDTH:0]   sum;
  logic [WIDTH:0]   trial;

  always_comb begin
    addend = shreg_i[0] ? opnd_i : '0;
    sum    = {1'b0, acc_i} + {1'b0, addend};
    // The remainder stays below the divisor, so bit WIDTH of the trial
    // difference is a clean borrow flag.
    trial  = {acc_i, shreg_i[WIDTH-1]} - {1'b0, opnd_i};
    if (is_div) begin
      if (!trial[WIDTH]) begin
        acc_o   = trial[WIDTH-1:0];
        shreg_o = {shreg_i[WIDTH-2:0], 1'b1};
      end else begin
        acc_o   = {acc_i[WIDTH-2:0], shreg_i[WIDTH-1]};
        shreg_o = {shreg_i[WIDTH-2:0], 1'b0};
      end
    end else begin
      // Shift {carry, acc, shreg} right by one; product builds up in {acc, shreg}.
      acc_o   = sum[WIDTH:1];
      shreg_o = {sum[0], shreg_i[WIDTH-1:1]};
    end
  end

endmodule

// File: rtl/muldiv_sequencer.sv
// Multi-cycle MULT/MULTU/DIV/DIVU sequencer owning the HI/LO register pair.
//   Clk, Reset_n      : clock and synchronous active-low reset
//   Start, Op, A, B   : issue request, operation, rs / rt operands
//   WrHi, WrLo, WrData: MTHI / MTLO writes (only while not busy)
//   Flush             : abort any in-flight operation
//   Busy              : high in CALC and FIX
//   Done              : one-cycle pulse when HI/LO hold a new result
//   DivZero           : set when a divide was issued with B == 0
//   Hi, Lo            : HI / LO registers
module muldiv_sequencer
  import muldiv_pkg::*;
#(
  parameter int WIDTH = MD_WIDTH,
  parameter int CNT_W = 5
) (
  input  logic             Clk,
  input  logic             Reset_n,
  input  logic             Start,
  input  logic [1:0]       Op,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             WrHi,
  input  logic             WrLo,
  input  logic [WIDTH-1:0] WrData,
  input  logic             Flush,
  output logic             Busy,
  output logic             Done,
  output logic             DivZero,
  output logic [WIDTH-1:0] Hi,
  output logic [WIDTH-1:0] Lo
);

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0] acc_q, acc_d;
  logic [WIDTH-1:0] shreg_q, shreg_d;
  logic [WIDTH-1:0] opnd_q, opnd_d;
  logic [WIDTH-1:0] hi_q, hi_d;
  logic [WIDTH-1:0] lo_q, lo_d;
  logic             is_div_q, is_div_d;
  logic             neg_res_q, neg_res_d;  // negate product / quotient
  logic             neg_rem_q, neg_rem_d;  // negate remainder
  logic             divzero_q, divzero_d;

  logic [WIDTH-1:0]   step_acc, step_shreg;
  logic               idle_or_done, start_acc;
  logic               signed_op, div_op, a_neg, b_neg, div_zero;
  logic [WIDTH-1:0]   a_mag, b_mag;
  logic [2*WIDTH-1:0] prod, prod_fix;

  muldiv_step #(.WIDTH(WIDTH)) u_step (
    .is_div  (is_div_q),
    .acc_i   (acc_q),
    .shreg_i (shreg_q),
    .opnd_i  (opnd_q),
    .acc_o   (step_acc),
    .shreg_o (step_shreg)
  );

  assign idle_or_done = (state_q == S_IDLE) || (state_q == S_DONE);
  assign start_acc    = Start && idle_or_done && !Flush;

  // Operand conditioning for a newly accepted operation.
  assign signed_op = (Op == OP_MULT) || (Op == OP_DIV);
  assign div_op    = Op[1];
  assign a_neg     = signed_op && A[WIDTH-1];
  assign b_neg     = signed_op && B[WIDTH-1];
  assign a_mag     = a_neg ? (~A + 1'b1) : A;
  assign b_mag     = b_neg ? (~B + 1'b1) : B;
  assign div_zero  = div_op && (B == '0);

  assign prod     = {acc_q, shreg_q};
  assign prod_fix = neg_res_q ? (~prod + 1'b1) : prod;

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    acc_d     = acc_q;
    shreg_d   = shreg_q;
    opnd_d    = opnd_q;
    hi_d      = hi_q;
    lo_d      = lo_q;
    is_div_d  = is_div_q;
    neg_res_d = neg_res_q;
    neg_rem_d = neg_rem_q;
    divzero_d = divzero_q;

    // MT writes only when idle and not displaced by an accepted Start.
    if (idle_or_done && !start_acc) begin
      if (WrHi) hi_d = WrData;
      if (WrLo) lo_d = WrData;
    end

    if (Flush) begin
      state_d = S_IDLE;
      cnt_d   = '0;
    end else begin
      case (state_q)
        S_IDLE, S_DONE: begin
          state_d = S_IDLE;
          if (start_acc) begin
            cnt_d     = '0;
            is_div_d  = div_op;
            divzero_d = div_zero;
            if (div_zero) begin
              // Preload the FIX inputs so the normal divide path yields
              // Lo = all ones and Hi = raw A.
              acc_d     = A;
              shreg_d   = '1;
              neg_res_d = 1'b0;
              neg_rem_d = 1'b0;
              state_d   = S_FIX;
            end else begin
              acc_d     = '0;
              shreg_d   = div_op ? a_mag : b_mag;
              opnd_d    = div_op ? b_mag : a_mag;
              neg_res_d = a_neg ^ b_neg;
              neg_rem_d = div_op && a_neg;
              state_d   = S_CALC;
            end
          end
        end
        S_CALC: begin
          acc_d   = step_acc;
          shreg_d = step_shreg;
          cnt_d   = cnt_q + 1'b1;
          if (cnt_q == CNT_W'(WIDTH - 1)) state_d = S_FIX;
        end
        S_FIX: begin
          if (is_div_q) begin
            lo_d = neg_res_q ? (~shreg_q + 1'b1) : shreg_q;
            hi_d = neg_rem_q ? (~acc_q + 1'b1) : acc_q;
          end else begin
            hi_d = prod_fix[2*WIDTH-1:WIDTH];
            lo_d = prod_fix[WIDTH-1:0];
          end
          state_d = S_DONE;
        end
        default: state_d = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge Clk) begin
    if (!Reset_n) begin
      state_q   <= S_IDLE;
      cnt_q     <= '0;
      acc_q     <= '0;
      shreg_q   <= '0;
      opnd_q    <= '0;
      hi_q      <= '0;
      lo_q      <= '0;
      is_div_q  <= 1'b0;
      neg_res_q <= 1'b0;
      neg_rem_q <= 1'b0;
      divzero_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      acc_q     <= acc_d;
      shreg_q   <= shreg_d;
      opnd_q    <= opnd_d;
      hi_q      <= hi_d;
      lo_q      <= lo_d;
      is_div_q  <= is_div_d;
      neg_res_q <= neg_res_d;
      neg_rem_q <= neg_rem_d;
      divzero_q <= divzero_d;
    end
  end

  assign Busy    = (state_q == S_CALC) || (state_q == S_FIX);
  assign Done    = (state_q == S_DONE);
  assign DivZero = divzero_q;
  assign Hi      = hi_q;
  assign Lo      = lo_q;

endmodule

// File: tb/tb_muldiv_sequencer.sv
// Directed bench for muldiv_sequencer with hand-computed expected results.
module tb_muldiv_sequencer;
  import muldiv_pkg::*;

  logic        Clk = 1'b0;
  logic        Reset_n = 1'b0;
  logic        Start = 1'b0;
  logic [1:0]  Op = 2'b00;
  logic [31:0] A = '0;
  logic [31:0] B = '0;
  logic        WrHi = 1'b0;
  logic        WrLo = 1'b0;
  logic [31:0] WrData = '0;
  logic        Flush = 1'b0;
  logic        Busy, Done, DivZero;
  logic [31:0] Hi, Lo;

  int vectors = 0;
  int miscompares = 0;

  muldiv_sequencer #(.WIDTH(32), .CNT_W(5)) dut (
    .Clk(Clk), .Reset_n(Reset_n), .Start(Start), .Op(Op), .A(A), .B(B),
    .WrHi(WrHi), .WrLo(WrLo), .WrData(WrData), .Flush(Flush),
    .Busy(Busy), .Done(Done), .DivZero(DivZero), .Hi(Hi), .Lo(Lo)
  );

  always #5 Clk = ~Clk;

  task automatic tick();
    @(posedge Clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp)
    else begin
      miscompares++;
      $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  // Present Start for the edge that ends the current cycle (t0); returns in t1.
  task automatic start_op(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
    Start = 1'b1; Op = op; A = a; B = b;
    tick();
    Start = 1'b0; WrHi = 1'b0; WrLo = 1'b0;
  endtask

  // Called in t1; waits (bounded) for Done and checks latency, Busy and results.
  task automatic wait_done(input string tag, input int lat, input logic [31:0] hi,
                           input logic [31:0] lo, input logic dz);
    int   k;
    logic busy_all;
    k = 1;
    busy_all = 1'b1;
    while (!Done && k < 60) begin
      busy_all &= Busy;
      tick();
      k++;
    end
    $display("txn %s: done at t%0d hi=0x%08h lo=0x%08h divzero=%0b", tag, k, Hi, Lo, DivZero);
    check({tag, " latency"}, 32'(k), 32'(lat));
    check({tag, " busy"}, 32'(busy_all), 32'd1);
    check({tag, " hi"}, Hi, hi);
    check({tag, " lo"}, Lo, lo);
    check({tag, " divzero"}, 32'(DivZero), 32'(dz));
  endtask

  initial begin
    int done_seen;

    // Reset held for three cycles.
    repeat (3) tick();
    Reset_n = 1'b1;
    tick();
    $display("txn reset: hi=0x%08h lo=0x%08h busy=%0b done=%0b", Hi, Lo, Busy, Done);
    check("reset hi", Hi, 32'h0);
    check("reset lo", Lo, 32'h0);
    check("reset busy", 32'(Busy), 32'd0);
    check("reset done", 32'(Done), 32'd0);
    check("reset divzero", 32'(DivZero), 32'd0);

    start_op(OP_MULT, 32'hFFFF_FFFD, 32'd7);
    wait_done("mult -3*7", 34, 32'hFFFF_FFFF, 32'hFFFF_FFEB, 1'b0);
    tick();
    check("done pulse width", 32'(Done), 32'd0);

    start_op(OP_MULTU, 32'hFFFF_FFFD, 32'd7);
    wait_done("multu", 34, 32'h0000_0006, 32'hFFFF_FFEB, 1'b0);
    tick();

    start_op(OP_DIV, 32'hFFFF_FFF9, 32'd2);
    wait_done("div -7/2", 34, 32'hFFFF_FFFF, 32'hFFFF_FFFD, 1'b0);
    tick();

    start_op(OP_DIVU, 32'h8000_0000, 32'hFFFF_FFFF);
    wait_done("divu big", 34, 32'h8000_0000, 32'h0000_0000, 1'b0);
    tick();

    start_op(OP_DIV, 32'h8000_0000, 32'hFFFF_FFFF);
    wait_done("div min/-1", 34, 32'h0000_0000, 32'h8000_0000, 1'b0);
    tick();

    start_op(OP_DIVU, 32'h0000_1234, 32'h0);
    wait_done("divu by 0", 2, 32'h0000_1234, 32'hFFFF_FFFF, 1'b1);
    tick();
    check("divzero sticky", 32'(DivZero), 32'd1);

    // Start while busy, MTHI while busy, then Flush during t10.
    start_op(OP_MULTU, 32'd5, 32'd3);
    check("divzero cleared", 32'(DivZero), 32'd0);
    tick(); tick();                        // now t3
    Start = 1'b1; Op = OP_DIVU; A = 32'd9; B = 32'd0;
    WrHi = 1'b1; WrData = 32'hDEAD_BEEF;
    tick();                                // t4
    Start = 1'b0; WrHi = 1'b0;
    check("start ignored divzero", 32'(DivZero), 32'd0);
    repeat (6) tick();                     // t10
    Flush = 1'b1;
    tick();                                // t11
    Flush = 1'b0;
    $display("txn flush: busy=%0b done=%0b hi=0x%08h lo=0x%08h", Busy, Done, Hi, Lo);
    check("flush busy", 32'(Busy), 32'd0);
    check("flush hi", Hi, 32'h0000_1234);
    check("flush lo", Lo, 32'hFFFF_FFFF);
    done_seen = 0;
    for (int i = 0; i < 40; i++) begin
      if (Done || Busy) done_seen++;
      tick();
    end
    check("flush no done", 32'(done_seen), 32'd0);

    // Back-to-back issue: Start in the Done cycle.
    start_op(OP_MULT, 32'd2, 32'd3);
    wait_done("b2b first", 34, 32'h0, 32'h6, 1'b0);
    start_op(OP_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    wait_done("b2b second", 34, 32'hFFFF_FFFE, 32'h0000_0001, 1'b0);
    tick();
    check("b2b idle", 32'(Busy | Done), 32'd0);

    // MTHI + MTLO together in IDLE.
    WrHi = 1'b1; WrLo = 1'b1; WrData = 32'hA5A5_A5A5;
    tick();
    WrHi = 1'b0; WrLo = 1'b0;
    $display("txn mt both: hi=0x%08h lo=0x%08h", Hi, Lo);
    check("mt hi", Hi, 32'hA5A5_A5A5);
    check("mt lo", Lo, 32'hA5A5_A5A5);

    // Start and MTLO in the same cycle: the write is dropped.
    WrLo = 1'b1; WrData = 32'h1234_5678;
    start_op(OP_MULTU, 32'd4, 32'd5);
    check("start beats mtlo", Lo, 32'hA5A5_A5A5);
    wait_done("multu 4*5", 34, 32'h0, 32'd20, 1'b0);
    tick();

    // Reset in the middle of an operation.
    start_op(OP_MULT, 32'd9, 32'd9);
    repeat (5) tick();
    Reset_n = 1'b0;
    tick();
    Reset_n = 1'b1;
    $display("txn mid reset: busy=%0b hi=0x%08h lo=0x%08h", Busy, Hi, Lo);
    check("mid reset busy", 32'(Busy), 32'd0);
    check("mid reset lo", Lo, 32'h0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
